trig_table_loader: RTL

Runtime writer for the per-bin sine/cosine reference tables and the per-bin wrap lengths (BinMax). It sits between a host/config stream and the trig table RAMs that the bin counters read. It takes a framed word stream and issues RAM write strobes at address {bin, position}. It asserts `tables_valid` only after all BINS bins have loaded cleanly. It is the write side of the table-lookup path that the correlator's sin/cos readers and counters consume.

---
 rtl/trig_pkg.sv | 21 ++
 rtl/trig_loader_checksum.sv | 29 ++
 rtl/trig_table_loader.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/trig_pkg.sv
// Shared constants and loader state encoding for the trig table path.
// TRIG_LOADER_CHECKSUM_EN adds the per-bin checksum state.
package trig_pkg;
    localparam int TRIG_N    = 16;
    localparam int TRIG_BINS = 24;
    localparam int TRIG_NS   = 6;
    localparam int BIN_W     = $clog2(TRIG_BINS);
    localparam int ADDR_W    = BIN_W + TRIG_NS;

    typedef enum logic [2:0] {
        IDLE,
        LEN,
        SIN,
        COS,
`ifdef TRIG_LOADER_CHECKSUM_EN
        CHK,
`endif
        FINISH,
        ERR
    } loader_state_t;
endpackage

// File: rtl/trig_loader_checksum.sv
// Running modulo-2**N sum of one bin's stream words, with compare against
// the trailing checksum word.
module trig_loader_checksum
    import trig_pkg::*;
#(
    parameter int N = TRIG_N
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         add,
    input  logic [N-1:0] din,
    output logic         match
);
    logic [N-1:0] sum;

    // clr and add together restart the sum at the current word
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum <= '0;
        end else if (clr) begin
            sum <= add ? din : '0;
        end else if (add) begin
            sum <= sum + din;
        end
    end

    assign match = (din == sum);
endmodule

// File: rtl/trig_table_loader.sv
// Framed-stream writer for the per-bin sine/cosine tables and BinMax lengths.
// Define TRIG_LOADER_CHECKSUM_EN for a per-bin checksum word after the cosines.
module trig_table_loader
    import trig_pkg::*;
#(
    parameter int N    = TRIG_N,
    parameter int BINS = TRIG_BINS,
    parameter int NS   = TRIG_NS
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       load_start,
    input  logic [N-1:0]               in_data,
    input  logic                       in_valid,
    output logic                       in_ready,
    output logic                       sin_we,
    output logic                       cos_we,
    output logic [$clog2(BINS)+NS-1:0] wr_addr,
    output logic [N-1:0]               wr_data,
    output logic                       binmax_we,
    output logic [$clog2(BINS)-1:0]    binmax_bin,
    output logic [NS-1:0]              binmax_value,
    output logic                       busy,
    output logic                       done,
    output logic                       error,
    output logic                       tables_valid
);
    localparam int BW = $clog2(BINS);
    localparam int AW = BW + NS;

    loader_state_t state, state_n;
    logic [BW-1:0] bin, bin_n;
    logic [NS-1:0] pos, pos_n, len, len_n;
    logic          sin_we_n, cos_we_n, binmax_we_n, done_n, error_n, tv_n;
    logic [AW-1:0] wr_addr_n;
    logic [N-1:0]  wr_data_n;
    logic [BW-1:0] binmax_bin_n;
    logic [NS-1:0] binmax_value_n;
    logic          hs, advance;

`ifdef TRIG_LOADER_CHECKSUM_EN
    logic sum_clr, sum_add, sum_match;

    trig_loader_checksum #(.N(N)) u_checksum (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (sum_clr),
        .add   (sum_add),
        .din   (in_data),
        .match (sum_match)
    );
`endif

    always_comb begin
        in_ready = (state == LEN) || (state == SIN) || (state == COS);
`ifdef TRIG_LOADER_CHECKSUM_EN
        if (state == CHK) in_ready = 1'b1;
`endif
    end

    assign hs   = in_valid && in_ready;
    assign busy = (state != IDLE) && (state != ERR);

    always_comb begin
        state_n        = state;
        bin_n          = bin;
        pos_n          = pos;
        len_n          = len;
        sin_we_n       = 1'b0;
        cos_we_n       = 1'b0;
        binmax_we_n    = 1'b0;
        wr_addr_n      = wr_addr;
        wr_data_n      = wr_data;
        binmax_bin_n   = binmax_bin;
        binmax_value_n = binmax_value;
        done_n         = 1'b0;
        error_n        = error;
        tv_n           = tables_valid;
        advance        = 1'b0;
`ifdef TRIG_LOADER_CHECKSUM_EN
        sum_clr        = 1'b0;
        sum_add        = 1'b0;
`endif
        case (state)
            IDLE, ERR: begin
                if (load_start) begin
                    state_n = LEN;
                    bin_n   = '0;
                    error_n = 1'b0;
                    tv_n    = 1'b0;
                end
            end
            LEN: begin
                if (hs) begin
                    if (in_data[NS-1:0] == '0 || in_data[N-1:NS] != '0) begin
                        state_n = ERR;
                        error_n = 1'b1;
                        tv_n    = 1'b0;
                    end else begin
                        len_n          = in_data[NS-1:0];
                        binmax_we_n    = 1'b1;
                        binmax_bin_n   = bin;
                        binmax_value_n = in_data[NS-1:0];
                        pos_n          = '0;
                        state_n        = SIN;
`ifdef TRIG_LOADER_CHECKSUM_EN
                        sum_clr        = 1'b1;
                        sum_add        = 1'b1;
`endif
                    end
                end
            end
            SIN, COS: begin
                if (hs) begin
                    sin_we_n  = (state == SIN);
                    cos_we_n  = (state == COS);
                    wr_addr_n = {bin, pos};
                    wr_data_n = in_data;
`ifdef TRIG_LOADER_CHECKSUM_EN
                    sum_add   = 1'b1;
`endif
                    if (pos == len - NS'(1)) begin
                        pos_n = '0;
                        if (state == SIN) begin
                            state_n = COS;
                        end else begin
`ifdef TRIG_LOADER_CHECKSUM_EN
                            state_n = CHK;
`else
                            advance = 1'b1;
`endif
                        end
                    end else begin
                        pos_n = pos + NS'(1);
                    end
                end
            end
`ifdef TRIG_LOADER_CHECKSUM_EN
            CHK: begin
                if (hs) begin
                    if (sum_match) begin
                        advance = 1'b1;
                    end else begin
                        state_n = ERR;
                        error_n = 1'b1;
                        tv_n    = 1'b0;
                    end
                end
            end
`endif
            FINISH: begin
                done_n  = 1'b1;
                tv_n    = 1'b1;
                state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase

        // shared end-of-bin step, reached from COS or CHK
        if (advance) begin
            if (bin == BW'(BINS - 1)) begin
                state_n = FINISH;
            end else begin
                bin_n   = bin + BW'(1);
                state_n = LEN;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            bin          <= '0;
            pos          <= '0;
            len          <= '0;
            sin_we       <= 1'b0;
            cos_we       <= 1'b0;
            binmax_we    <= 1'b0;
            wr_addr      <= '0;
            wr_data      <= '0;
            binmax_bin   <= '0;
            binmax_value <= '0;
            done         <= 1'b0;
            error        <= 1'b0;
            tables_valid <= 1'b0;
        end else begin
            state        <= state_n;
            bin          <= bin_n;
            pos          <= pos_n;
            len          <= len_n;
            sin_we       <= sin_we_n;
            cos_we       <= cos_we_n;
            binmax_we    <= binmax_we_n;
            wr_addr      <= wr_addr_n;
            wr_data      <= wr_data_n;
            binmax_bin   <= binmax_bin_n;
            binmax_value <= binmax_value_n;
            done         <= done_n;
            error        <= error_n;
            tables_valid <= tv_n;
        end
    end
endmodule
